// File: rtl/crc_checker.sv
// CAN CRC-15 serial checker: accumulates the frame CRC, latches it at the start
// of the received CRC field, and flags a zero/non-zero remainder after 15 field bits.
module crc_checker (
    input  logic        clock,
    input  logic        CLEAR_N,
    input  logic        INIT,
    input  logic        BITEN,
    input  logic        BITVAL,
    input  logic        CRC_FIELD,
    output logic [14:0] CRC,
    output logic [14:0] CRC_TX,
    output logic [7:0]  BITCNT,
    output logic        CRC_OK,
    output logic        CRC_ERR,
    output logic        BUSY
);

    localparam int unsigned CRC_W      = 15;
    localparam int unsigned CNT_W      = 8;
    localparam int unsigned FCNT_W     = 4;
    localparam int unsigned FIELD_BITS = 15;
    localparam logic [CRC_W-1:0] POLY  = 15'h4599;

    typedef enum logic [1:0] {
        CALC  = 2'd0,
        CHECK = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CRC_W-1:0]   crc_q, crc_d;
    logic [CRC_W-1:0]   tx_q, tx_d;
    logic [CNT_W-1:0]   bitcnt_q, bitcnt_d;
    logic [FCNT_W-1:0]  fcnt_q, fcnt_d;
    logic               ok_q, ok_d;
    logic               err_q, err_d;
    logic               busy_q, busy_d;

    // One MSB-first LFSR step; the bit shifted out of the top is dropped.
    function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] c, input logic b);
        logic [CRC_W-1:0] s;
        s = {c[CRC_W-2:0], 1'b0};
        if (b ^ c[CRC_W-1]) begin
            s = s ^ POLY;
        end
        return s;
    endfunction

    // Next-state and next-output logic. INIT rewrites the working copies first so
    // a bit arriving in the same cycle is processed as the first frame bit.
    always_comb begin
        state_d  = state_q;
        crc_d    = crc_q;
        tx_d     = tx_q;
        bitcnt_d = bitcnt_q;
        fcnt_d   = fcnt_q;
        ok_d     = ok_q;
        err_d    = err_q;

        if (INIT) begin
            state_d  = CALC;
            crc_d    = '0;
            bitcnt_d = '0;
            fcnt_d   = '0;
            ok_d     = 1'b0;
            err_d    = 1'b0;
        end

        case (state_d)
            CALC: begin
                if (BITEN) begin
                    if (!CRC_FIELD) begin
                        crc_d = crc_step(crc_d, BITVAL);
                        if (bitcnt_d != '1) begin
                            bitcnt_d = bitcnt_d + CNT_W'(1);
                        end
                    end else begin
                        tx_d    = crc_d;
                        crc_d   = crc_step(crc_d, BITVAL);
                        fcnt_d  = FCNT_W'(1);
                        state_d = CHECK;
                    end
                end
            end
            CHECK: begin
                if (BITEN) begin
                    if (CRC_FIELD) begin
                        crc_d  = crc_step(crc_d, BITVAL);
                        fcnt_d = fcnt_d + FCNT_W'(1);
                        if (fcnt_d == FCNT_W'(FIELD_BITS)) begin
                            state_d = DONE;
                            ok_d    = (crc_d == '0);
                            err_d   = (crc_d != '0);
                        end
                    end else begin
                        // Field ended early: the partial field bit is not folded in.
                        state_d = DONE;
                        ok_d    = 1'b0;
                        err_d   = 1'b1;
                    end
                end
            end
            DONE: begin
            end
            default: begin
                state_d = CALC;
            end
        endcase

        busy_d = (state_d != DONE);
    end

    // State and output registers with synchronous clear.
    always_ff @(posedge clock) begin
        if (!CLEAR_N) begin
            state_q  <= CALC;
            crc_q    <= '0;
            tx_q     <= '0;
            bitcnt_q <= '0;
            fcnt_q   <= '0;
            ok_q     <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            crc_q    <= crc_d;
            tx_q     <= tx_d;
            bitcnt_q <= bitcnt_d;
            fcnt_q   <= fcnt_d;
            ok_q     <= ok_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
        end
    end

    assign CRC     = crc_q;
    assign CRC_TX  = tx_q;
    assign BITCNT  = bitcnt_q;
    assign CRC_OK  = ok_q;
    assign CRC_ERR = err_q;
    assign BUSY    = busy_q;

endmodule

// File: tb/tb_crc_checker.sv
// Directed bench for crc_checker: the driver queues hand-computed expectations,
// a monitor pops one per clock and compares every output.
module tb_crc_checker;

    logic        clock;
    logic        CLEAR_N;
    logic        INIT;
    logic        BITEN;
    logic        BITVAL;
    logic        CRC_FIELD;
    logic [14:0] CRC;
    logic [14:0] CRC_TX;
    logic [7:0]  BITCNT;
    logic        CRC_OK;
    logic        CRC_ERR;
    logic        BUSY;

    typedef struct {
        logic [14:0] crc;
        logic [14:0] tx;
        logic [7:0]  bc;
        logic        ok;
        logic        err;
        logic        busy;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    crc_checker dut (
        .clock     (clock),
        .CLEAR_N   (CLEAR_N),
        .INIT      (INIT),
        .BITEN     (BITEN),
        .BITVAL    (BITVAL),
        .CRC_FIELD (CRC_FIELD),
        .CRC       (CRC),
        .CRC_TX    (CRC_TX),
        .BITCNT    (BITCNT),
        .CRC_OK    (CRC_OK),
        .CRC_ERR   (CRC_ERR),
        .BUSY      (BUSY)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string nm, input string fld, input logic [14:0] act, input logic [14:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s.%s: got %h, expected %h", nm, fld, act, want);
        end
    endtask

    // Monitor: one expectation per clock, sampled 1 time unit after the edge.
    always @(posedge clock) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk(e.name, "crc",    CRC,             e.crc);
            chk(e.name, "crc_tx", CRC_TX,          e.tx);
            chk(e.name, "bitcnt", 15'(BITCNT),     15'(e.bc));
            chk(e.name, "ok",     15'(CRC_OK),     15'(e.ok));
            chk(e.name, "err",    15'(CRC_ERR),    15'(e.err));
            chk(e.name, "busy",   15'(BUSY),       15'(e.busy));
            chk(e.name, "excl",   15'(CRC_OK & CRC_ERR), 15'(0));
        end
    end

    // Drive one clock of inputs and queue what the outputs must be after that edge.
    task automatic cyc(input logic clr, input logic ini, input logic en, input logic v, input logic f,
                       input logic [14:0] ecrc, input logic [14:0] etx, input logic [7:0] ebc,
                       input logic eok, input logic eerr, input logic ebusy, input string nm);
        exp_t e;
        @(negedge clock);
        CLEAR_N   = clr;
        INIT      = ini;
        BITEN     = en;
        BITVAL    = v;
        CRC_FIELD = f;
        e.crc  = ecrc;
        e.tx   = etx;
        e.bc   = ebc;
        e.ok   = eok;
        e.err  = eerr;
        e.busy = ebusy;
        e.name = nm;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 15'h0, 15'h0, 8'd0, 1'b0, 1'b0, 1'b1, "reset");
    endtask

    // Message "1" followed by its own CRC 0x4599, optionally with the last field bit flipped.
    task automatic frame_check(input bit flip_last);
        logic [14:0] p;
        logic [14:0] ec;
        logic        b;
        bit          last;
        p = 15'h4599;
        do_reset();
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 15'h4599, 15'h0, 8'd1, 1'b0, 1'b0, 1'b1, "frame_bit");
        for (int k = 1; k <= 15; k++) begin
            last = (k == 15);
            b  = p[4'(15 - k)];
            ec = p << k;
            if (flip_last && last) begin
                b  = ~b;
                ec = 15'h4599;
            end
            cyc(1'b1, 1'b0, 1'b1, b, 1'b1, ec, 15'h4599, 8'd1,
                last && !flip_last, last && flip_last, !last, flip_last ? "field_bad" : "field_good");
        end
        for (int k = 0; k < 3; k++) begin
            cyc(1'b1, 1'b0, 1'b1, k[0], k[1], flip_last ? 15'h4599 : 15'h0, 15'h4599, 8'd1,
                !flip_last, flip_last, 1'b0, "done_hold");
        end
    endtask

    initial begin
        logic [14:0] p;
        CLEAR_N   = 1'b0;
        INIT      = 1'b0;
        BITEN     = 1'b0;
        BITVAL    = 1'b0;
        CRC_FIELD = 1'b0;

        // Single-bit and two-bit frames.
        do_reset();
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 15'h4599, 15'h0, 8'd1, 1'b0, 1'b0, 1'b1, "bit1");
        do_reset();
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 15'h0000, 15'h0, 8'd1, 1'b0, 1'b0, 1'b1, "bit0");
        do_reset();
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 15'h4599, 15'h0, 8'd1, 1'b0, 1'b0, 1'b1, "bits11_a");
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 15'h0B32, 15'h0, 8'd2, 1'b0, 1'b0, 1'b1, "bits11_b");
        do_reset();
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 15'h4599, 15'h0, 8'd1, 1'b0, 1'b0, 1'b1, "bits10_a");
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 15'h4EAB, 15'h0, 8'd2, 1'b0, 1'b0, 1'b1, "bits10_b");

        // Full field check, good then corrupted.
        frame_check(1'b0);
        frame_check(1'b1);

        // Aborted field after 7 bits, then INIT with a bit in the same cycle.
        p = 15'h4599;
        do_reset();
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 15'h4599, 15'h0, 8'd1, 1'b0, 1'b0, 1'b1, "abort_bit");
        for (int k = 1; k <= 7; k++) begin
            cyc(1'b1, 1'b0, 1'b1, p[4'(15 - k)], 1'b1, p << k, 15'h4599, 8'd1, 1'b0, 1'b0, 1'b1, "abort_field");
        end
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 15'h4C80, 15'h4599, 8'd1, 1'b0, 1'b1, 1'b0, "abort");
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 15'h4C80, 15'h4599, 8'd1, 1'b0, 1'b1, 1'b0, "abort_hold");
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 15'h4C80, 15'h4599, 8'd1, 1'b0, 1'b1, 1'b0, "abort_hold");
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 15'h4599, 15'h4599, 8'd1, 1'b0, 1'b0, 1'b1, "init_bit");

        // Idle bus in CALC and CHECK, then clear mid-check.
        do_reset();
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 15'h4599, 15'h0, 8'd1, 1'b0, 1'b0, 1'b1, "idle_a");
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 15'h4EAB, 15'h0, 8'd2, 1'b0, 1'b0, 1'b1, "idle_b");
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 15'h4EAB, 15'h0, 8'd2, 1'b0, 1'b0, 1'b1, "calc_idle");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 15'h4EAB, 15'h0, 8'd2, 1'b0, 1'b0, 1'b1, "calc_idle");
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 15'h1D56, 15'h4EAB, 8'd2, 1'b0, 1'b0, 1'b1, "chk_f1");
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 15'h3AAC, 15'h4EAB, 8'd2, 1'b0, 1'b0, 1'b1, "chk_f2");
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 15'h7558, 15'h4EAB, 8'd2, 1'b0, 1'b0, 1'b1, "chk_f3");
        for (int k = 0; k < 10; k++) begin
            cyc(1'b1, 1'b0, 1'b0, k[0], k[1], 15'h7558, 15'h4EAB, 8'd2, 1'b0, 1'b0, 1'b1, "check_idle");
        end
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 15'h0, 15'h0, 8'd0, 1'b0, 1'b0, 1'b1, "clear_in_check");
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 15'h0, 15'h0, 8'd0, 1'b0, 1'b0, 1'b1, "clear_over_init");

        // Bit counter saturation with an all-zero frame.
        do_reset();
        for (int k = 1; k <= 260; k++) begin
            cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 15'h0, 15'h0, (k > 255) ? 8'd255 : 8'(k),
                1'b0, 1'b0, 1'b1, "saturate");
        end

        // Let the monitor drain the queue, bounded.
        for (int k = 0; k < 10 && exp_q.size() > 0; k++) begin
            @(negedge clock);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/crc_checker.md
CRC_CHECKER -- requirements
Module: crc_checker

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset.
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clock  input  1  rising-edge clock, all state updates on it
- CLEAR_N  input  1  synchronous active-low reset
- INIT  input  1  synchronous start-of-frame restart
- BITEN  input  1  BITVAL is a valid bus bit this cycle
- BITVAL  input  1  serial bit, MSB-first frame order
- CRC_FIELD  input  1  high while the bits presented are the received 15-bit CRC field
- CRC  output  15  live CRC shift register
- CRC_TX  output  15  CRC computed over frame bits preceding CRC field
- BITCNT  output  8  count of frame bits accepted in CALC
- CRC_OK  output  1  check finished, remainder zero
- CRC_ERR  output  1  check finished with mismatch or aborted field
- BUSY  output  1  high in CALC or CHECK

Function
REQ-003 The polynomial SHALL be CAN CRC-15, x^15+x^14+x^10+x^8+x^7+x^4+x^3+1 (0x4599).
REQ-004 The per-bit update SHALL be: nxt = BITVAL XOR CRC[14]; CRC <= {CRC[13:0],0}; if nxt, CRC <= that value XOR 0x4599. All arithmetic is 15 bits, with the shifted-out bit discarded.
REQ-005 The CRC SHALL update only on a rising edge with BITEN=1 in CALC or CHECK, and SHALL hold otherwise. Latency is one clock from the sampled bit to the new CRC.
REQ-006 The states SHALL be CALC, CHECK and DONE. BUSY=1 in CALC and CHECK.
REQ-007 CALC, BITEN=1, CRC_FIELD=0: update CRC, BITCNT+1 (saturating at 255).
REQ-008 CALC, BITEN=1, CRC_FIELD=1:
- CRC_TX <= current CRC (pre-update)
- the bit is the first CRC-field bit: update CRC, field counter = 1
- BITCNT unchanged
- go to CHECK
REQ-009 CHECK, BITEN=1, CRC_FIELD=1: update CRC and increment the field counter. On the 15th field bit:
- go to DONE
- CRC_OK = (updated CRC == 0)
- CRC_ERR = NOT CRC_OK
REQ-010 CHECK, BITEN=1, CRC_FIELD=0 before 15 field bits (abort): CRC not updated, CRC_ERR=1, CRC_OK=0, go to DONE.
REQ-011 CHECK, BITEN=0: hold all state. A CRC_FIELD change without BITEN SHALL be ignored.
REQ-012 DONE: ignore BITEN, BITVAL and CRC_FIELD. Hold CRC, CRC_TX, BITCNT and the flags until INIT or reset.
REQ-013 INIT=1 (any state) SHALL:
- set CRC=0, BITCNT=0, field counter=0, CRC_OK=0, CRC_ERR=0
- set the state to CALC
- leave CRC_TX unchanged
REQ-014 If INIT=1 and BITEN=1 in the same cycle, the bit SHALL be processed as the first frame bit from CRC=0. The result is BITCNT=1, and CALC→CHECK if CRC_FIELD=1.
REQ-015 CRC_OK and CRC_ERR SHALL never be 1 simultaneously and SHALL be 0 outside DONE.
REQ-016 All outputs SHALL be registered; there is no combinational input-to-output path.

Reset
REQ-017 CLEAR_N=0 at a rising edge SHALL, with priority over INIT and BITEN, set:
- CRC=0, CRC_TX=0, BITCNT=0, field counter=0
- CRC_OK=0, CRC_ERR=0
- state CALC, BUSY=1
REQ-018 Reset asserted mid-CHECK SHALL abandon the check with no flag asserted.

Verification
REQ-019 Reset, then one bit 1 with BITEN → CRC=0x4599, BITCNT=1. Reset, then bit 0 → CRC=0x0000, BITCNT=1.
REQ-020 Reset, then bits 1,1 → CRC=0x0B32. Reset, then bits 1,0 → CRC=0x4EAB, BITCNT=2.
REQ-021 Reset, then bit 1, then the 15 bits of 0x4599 MSB-first with CRC_FIELD=1, checking at each step:
- after the 1st field bit: CRC_TX=0x4599, state CHECK
- after the 15th field bit: CRC=0, CRC_OK=1, CRC_ERR=0, BUSY=0, BITCNT=1
REQ-022 Same as REQ-021 with the last field bit inverted → after the 15th field bit: CRC_ERR=1, CRC_OK=0, CRC≠0.
REQ-023 CRC_FIELD dropped after 7 field bits with BITEN=1 → CRC_ERR=1 and CRC frozen. Then INIT=1 with BITEN=1 and BITVAL=1 → CRC=0x4599, BITCNT=1, flags 0, CRC_TX held.
REQ-024 BITEN=0 for 10 cycles while BITVAL toggles → CRC, BITCNT and state unchanged. CLEAR_N=0 during CHECK → all outputs at reset values next cycle.
